wb_protocol_monitor: RTL and testbench
======================================

Name: wb_protocol_monitor

Overview:
Synthesizable, parametrised Wishbone classic-cycle protocol monitor for the SDRAM controller host port. It replaces simulation-only property checks with a registered checker usable in both testbench and silicon debug. It passively observes master and slave signals and reports sticky error flags, an error pulse and read/write transfer counters. It sits beside the wishbone-to-SDRAM bridge and drives no bus signal.

Parameters:
AW, 32, address width observed
DW, 32, data width; select width is DW/8
TIMEOUT, 16, max cycles from request to ack before timeout error (legal range 2..65535)
CNTW, 16, width of transfer counters

Ports:
wb_clk_i  in  1  wishbone clock; all logic on rising edge
wb_resetn  in  1  synchronous active-low reset
wb_cyc_i  in  1  observed cycle
wb_stb_i  in  1  observed strobe
wb_we_i  in  1  observed write enable
wb_sel_i  in  DW/8  observed byte selects
wb_adr_i  in  AW  observed address
wb_ack_i  in  1  observed slave ack (slave's wb_ack_o)
clr_i  in  1  clears sticky flags and counters
err_flags_o  out  5  sticky error vector
err_pulse_o  out  1  one-cycle pulse on any error event
rd_cnt_o  out  CNTW  completed reads
wr_cnt_o  out  CNTW  completed writes
busy_o  out  1  high in WAIT or TOUT

Behaviour:
- Reset (wb_resetn=0 at rising edge): state=IDLE, all outputs 0, captured adr/we/sel=0, lat_cnt=0, post_rst=1.
- req = wb_cyc_i & wb_stb_i. Latency = edges with req high up to and including ack edge; zero-wait = 1.
- Error bits (set at detecting edge, visible next cycle, held until clr_i or reset):
  [0] STB_NO_CYC: wb_stb_i=1 & wb_cyc_i=0, any state.
  [1] ACK_NO_REQ: wb_ack_i=1 & req=0.
  [2] REQ_UNSTABLE: in WAIT, adr/we/sel differ from captured, or req drops without ack.
  [3] TIMEOUT: lat_cnt reaches TIMEOUT in WAIT without ack.
  [4] POST_RST: wb_cyc_i or wb_stb_i high on first edge after reset release (post_rst=1); post_rst cleared after that edge.
- err_pulse_o=1 the cycle after any error event, even if the bit is already set.
- FSM:
  IDLE: req&ack -> count transfer (we selects rd/wr), stay IDLE. req&!ack -> capture adr/we/sel, lat_cnt=1, -> WAIT.
  WAIT: ack (req high) -> count, -> IDLE. !req -> REQ_UNSTABLE, -> IDLE. field change -> REQ_UNSTABLE, recapture, stay WAIT (lat_cnt continues). lat_cnt+1==TIMEOUT & !ack -> TIMEOUT, -> TOUT; else lat_cnt++.
  TOUT: ack with req -> count, -> IDLE. !req -> IDLE, no error. No further TIMEOUT events for same request.
- Back-to-back: stb held after ack is a new request, evaluated in IDLE next edge.
- Counters saturate at 2^CNTW-1; no wrap.
- clr_i: zeroes flags/counters; an error event or count in the same cycle wins (applied after clear). clr_i does not alter FSM state.
- Reset mid-transfer: FSM to IDLE, no error; POST_RST check armed.

Optional Feature:
WB_MON_LATENCY_EN: adds output max_lat_o (16 bits, reset 0, cleared by clr_i) holding max latency of any completed transfer (TOUT completions saturate at 65535). Without macro, port and logic absent; all else identical.

Test Plan:
- Reset, 1 cycle later cyc=1 stb=1 -> err_flags_o=5'b10000, err_pulse_o one cycle.
- Write adr=0x100 sel=4'hF, ack on 3rd req edge -> wr_cnt_o=1, flags 0, busy_o high 2 cycles; max_lat_o=3 if enabled.
- Read with adr changed 0x200->0x204 before ack -> flag[2], rd_cnt_o=1 after ack.
- stb held 16 cycles, no ack (TIMEOUT=16) -> flag[3] at 16th edge, state TOUT; ack on 20th -> rd_cnt_o=1, no second pulse.
- ack=1 with cyc=0 and separately stb=1 cyc=0 -> flags[1:0]=2'b11; clr_i with simultaneous ack_no_req -> flag[1] remains set, flag[0] cleared.
- 2^CNTW+3 zero-wait reads (CNTW=4) -> rd_cnt_o saturates at 15.

Source files
------------

// File: rtl/wb_protocol_monitor.sv
// Passive Wishbone classic-cycle checker: sticky error flags, error pulse, saturating rd/wr counters.
// Optional WB_MON_LATENCY_EN adds max_lat_o (largest completed-transfer latency).
module wb_protocol_monitor #(
    parameter int AW      = 32,
    parameter int DW      = 32,
    parameter int TIMEOUT = 16,
    parameter int CNTW    = 16
) (
    input  logic              wb_clk_i,
    input  logic              wb_resetn,
    input  logic              wb_cyc_i,
    input  logic              wb_stb_i,
    input  logic              wb_we_i,
    input  logic [DW/8-1:0]   wb_sel_i,
    input  logic [AW-1:0]     wb_adr_i,
    input  logic              wb_ack_i,
    input  logic              clr_i,
    output logic [4:0]        err_flags_o,
    output logic              err_pulse_o,
    output logic [CNTW-1:0]   rd_cnt_o,
    output logic [CNTW-1:0]   wr_cnt_o,
`ifdef WB_MON_LATENCY_EN
    output logic [15:0]       max_lat_o,
`endif
    output logic              busy_o
);

    typedef enum logic [1:0] {S_IDLE, S_WAIT, S_TOUT} state_t;

    state_t            state, state_nxt;
    logic [AW-1:0]     cap_adr;
    logic              cap_we;
    logic [DW/8-1:0]   cap_sel;
    logic [15:0]       lat_cnt;
    logic              post_rst;

    logic              req, done, fld_diff, capture;
    logic [16:0]       lat_inc;
    logic [15:0]       lat_inc_sat;
    logic [4:0]        err_evt;

    assign req         = wb_cyc_i & wb_stb_i;
    assign done        = req & wb_ack_i;
    assign lat_inc     = {1'b0, lat_cnt} + 17'd1;
    assign lat_inc_sat = lat_inc[16] ? 16'hFFFF : lat_inc[15:0];
    assign fld_diff    = (wb_adr_i != cap_adr) | (wb_we_i != cap_we) | (wb_sel_i != cap_sel);

    always_ff @(posedge wb_clk_i) begin
        if (!wb_resetn) state <= S_IDLE;
        else            state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE: if (req && !wb_ack_i) state_nxt = S_WAIT;
            S_WAIT: begin
                if (!req || wb_ack_i)                state_nxt = S_IDLE;
                else if (lat_inc == 17'(TIMEOUT))    state_nxt = S_TOUT;
            end
            S_TOUT: if (!req || wb_ack_i) state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    always_comb begin
        busy_o     = (state != S_IDLE);
        err_evt    = '0;
        err_evt[0] = wb_stb_i & ~wb_cyc_i;
        err_evt[1] = wb_ack_i & ~req;
        err_evt[2] = (state == S_WAIT) & (~req | fld_diff);
        err_evt[3] = (state == S_WAIT) & req & ~wb_ack_i & (lat_inc == 17'(TIMEOUT));
        err_evt[4] = post_rst & (wb_cyc_i | wb_stb_i);
        capture    = req & ~wb_ack_i & ((state == S_IDLE) | ((state == S_WAIT) & fld_diff));
    end

    // Clear is applied first so a same-cycle event or count survives it.
    always_ff @(posedge wb_clk_i) begin
        if (!wb_resetn) begin
            err_flags_o <= '0;
            err_pulse_o <= 1'b0;
            rd_cnt_o    <= '0;
            wr_cnt_o    <= '0;
            cap_adr     <= '0;
            cap_we      <= 1'b0;
            cap_sel     <= '0;
            lat_cnt     <= '0;
            post_rst    <= 1'b1;
        end else begin
            post_rst    <= 1'b0;
            err_pulse_o <= |err_evt;
            err_flags_o <= (clr_i ? 5'd0 : err_flags_o) | err_evt;

            if (clr_i)
                rd_cnt_o <= CNTW'(done & ~wb_we_i);
            else if (done && !wb_we_i && rd_cnt_o != {CNTW{1'b1}})
                rd_cnt_o <= rd_cnt_o + 1'b1;

            if (clr_i)
                wr_cnt_o <= CNTW'(done & wb_we_i);
            else if (done && wb_we_i && wr_cnt_o != {CNTW{1'b1}})
                wr_cnt_o <= wr_cnt_o + 1'b1;

            if (capture) begin
                cap_adr <= wb_adr_i;
                cap_we  <= wb_we_i;
                cap_sel <= wb_sel_i;
            end

            if (state == S_IDLE) begin
                if (req && !wb_ack_i) lat_cnt <= 16'd1;
            end else if (req && !wb_ack_i) begin
                lat_cnt <= lat_inc_sat;
            end
        end
    end

`ifdef WB_MON_LATENCY_EN
    logic [15:0] xfer_lat;
    assign xfer_lat = (state == S_IDLE) ? 16'd1 : lat_inc_sat;

    always_ff @(posedge wb_clk_i) begin
        if (!wb_resetn)
            max_lat_o <= '0;
        else if (clr_i)
            max_lat_o <= done ? xfer_lat : 16'd0;
        else if (done && xfer_lat > max_lat_o)
            max_lat_o <= xfer_lat;
    end
`endif

endmodule

// File: tb/tb_wb_protocol_monitor.sv
// Scoreboard bench for wb_protocol_monitor (CNTW=4, TIMEOUT=16, default build).
module tb_wb_protocol_monitor;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        cyc = 1'b0, stb = 1'b0, we = 1'b0, ack = 1'b0, clr = 1'b0;
    logic [3:0]  sel = '0;
    logic [31:0] adr = '0;
    logic [4:0]  flags;
    logic        pulse, busy;
    logic [3:0]  rd_cnt, wr_cnt;

    int checks   = 0;
    int failures = 0;

    typedef struct {
        string      tag;
        logic [4:0] flags;
        logic       pulse;
        logic [3:0] rd;
        logic [3:0] wr;
        logic       busy;
    } exp_t;

    exp_t exp_q[$];

    always #5 clk = ~clk;

    wb_protocol_monitor #(.AW(32), .DW(32), .TIMEOUT(16), .CNTW(4)) dut (
        .wb_clk_i    (clk),
        .wb_resetn   (rst_n),
        .wb_cyc_i    (cyc),
        .wb_stb_i    (stb),
        .wb_we_i     (we),
        .wb_sel_i    (sel),
        .wb_adr_i    (adr),
        .wb_ack_i    (ack),
        .clr_i       (clr),
        .err_flags_o (flags),
        .err_pulse_o (pulse),
        .rd_cnt_o    (rd_cnt),
        .wr_cnt_o    (wr_cnt),
        .busy_o      (busy)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic step(input logic r, input logic c, input logic s, input logic w,
                        input logic [3:0] sl, input logic [31:0] a, input logic k, input logic cl);
        @(negedge clk);
        rst_n = r; cyc = c; stb = s; we = w; sel = sl; adr = a; ack = k; clr = cl;
        @(posedge clk);
    endtask

    task automatic expect_out(input string tag, input logic [4:0] f, input logic p,
                              input logic [3:0] r, input logic [3:0] w, input logic b);
        exp_t e;
        e.tag = tag; e.flags = f; e.pulse = p; e.rd = r; e.wr = w; e.busy = b;
        exp_q.push_back(e);
    endtask

    always @(negedge clk) begin
        if (exp_q.size() != 0) begin
            exp_t e;
            e = exp_q.pop_front();
            chk({e.tag, ".flags"}, 32'(flags),  32'(e.flags));
            chk({e.tag, ".pulse"}, 32'(pulse),  32'(e.pulse));
            chk({e.tag, ".rd"},    32'(rd_cnt), 32'(e.rd));
            chk({e.tag, ".wr"},    32'(wr_cnt), 32'(e.wr));
            chk({e.tag, ".busy"},  32'(busy),   32'(e.busy));
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        step(0, 0, 0, 0, 4'h0, 32'h0, 0, 0);
        step(0, 0, 0, 0, 4'h0, 32'h0, 0, 0);
        expect_out("reset", 5'b00000, 0, 0, 0, 0);

        // Bus already active on the first edge after reset release.
        step(0, 1, 1, 0, 4'hF, 32'h0, 1, 0);
        step(1, 1, 1, 0, 4'hF, 32'h0, 1, 0);
        expect_out("post_rst", 5'b10000, 1, 1, 0, 0);
        step(1, 0, 0, 0, 4'h0, 32'h0, 0, 0);
        expect_out("post_rst_hold", 5'b10000, 0, 1, 0, 0);
        step(1, 0, 0, 0, 4'h0, 32'h0, 0, 1);
        expect_out("clr1", 5'b00000, 0, 0, 0, 0);

        step(1, 1, 1, 1, 4'hF, 32'h100, 0, 0);
        expect_out("wr_e1", 5'b00000, 0, 0, 0, 1);
        step(1, 1, 1, 1, 4'hF, 32'h100, 0, 0);
        expect_out("wr_e2", 5'b00000, 0, 0, 0, 1);
        step(1, 1, 1, 1, 4'hF, 32'h100, 1, 0);
        expect_out("wr_ack", 5'b00000, 0, 0, 1, 0);
        step(1, 0, 0, 0, 4'h0, 32'h0, 0, 0);

        step(1, 1, 1, 0, 4'hF, 32'h200, 0, 0);
        expect_out("rd_e1", 5'b00000, 0, 0, 1, 1);
        step(1, 1, 1, 0, 4'hF, 32'h204, 0, 0);
        expect_out("rd_adr_chg", 5'b00100, 1, 0, 1, 1);
        step(1, 1, 1, 0, 4'hF, 32'h204, 1, 0);
        expect_out("rd_ack", 5'b00100, 0, 1, 1, 0);
        step(1, 0, 0, 0, 4'h0, 32'h0, 0, 1);
        expect_out("clr2", 5'b00000, 0, 0, 0, 0);

        for (int i = 1; i <= 19; i++) begin
            step(1, 1, 1, 0, 4'h3, 32'h300, 0, 0);
            if (i == 15) expect_out("tout_e15", 5'b00000, 0, 0, 0, 1);
            if (i == 16) expect_out("tout_e16", 5'b01000, 1, 0, 0, 1);
            if (i == 17) expect_out("tout_e17", 5'b01000, 0, 0, 0, 1);
        end
        step(1, 1, 1, 0, 4'h3, 32'h300, 1, 0);
        expect_out("tout_ack", 5'b01000, 0, 1, 0, 0);
        step(1, 0, 0, 0, 4'h0, 32'h0, 0, 1);
        expect_out("clr3", 5'b00000, 0, 0, 0, 0);

        step(1, 0, 0, 0, 4'h0, 32'h0, 1, 0);
        expect_out("ack_no_req", 5'b00010, 1, 0, 0, 0);
        step(1, 0, 1, 0, 4'h0, 32'h0, 0, 0);
        expect_out("stb_no_cyc", 5'b00011, 1, 0, 0, 0);
        step(1, 0, 0, 0, 4'h0, 32'h0, 1, 1);
        expect_out("clr_vs_evt", 5'b00010, 1, 0, 0, 0);
        step(1, 0, 0, 0, 4'h0, 32'h0, 1, 0);
        expect_out("repeat_evt", 5'b00010, 1, 0, 0, 0);
        step(1, 0, 0, 0, 4'h0, 32'h0, 0, 0);
        expect_out("quiet", 5'b00010, 0, 0, 0, 0);
        step(1, 0, 0, 0, 4'h0, 32'h0, 0, 1);
        expect_out("clr4", 5'b00000, 0, 0, 0, 0);

        for (int i = 1; i <= 19; i++) begin
            step(1, 1, 1, 0, 4'hF, 32'(i * 4), 1, 0);
            expect_out($sformatf("sat_%0d", i), 5'b00000, 0, 4'((i > 15) ? 15 : i), 0, 0);
        end
        step(1, 1, 1, 0, 4'hF, 32'h0, 1, 1);
        expect_out("clr_vs_cnt", 5'b00000, 0, 1, 0, 0);

        step(1, 1, 1, 1, 4'hF, 32'h400, 0, 0);
        expect_out("mid_req", 5'b00000, 0, 1, 0, 1);
        step(0, 0, 0, 0, 4'h0, 32'h0, 0, 0);
        expect_out("mid_reset", 5'b00000, 0, 0, 0, 0);
        step(1, 0, 0, 0, 4'h0, 32'h0, 0, 0);
        expect_out("mid_post", 5'b00000, 0, 0, 0, 0);
        step(1, 1, 1, 1, 4'hF, 32'h500, 1, 0);
        expect_out("mid_after", 5'b00000, 0, 0, 1, 0);

        for (int n = 0; n < 4 && exp_q.size() != 0; n++) @(posedge clk);
        if (exp_q.size() != 0) chk("drain", 32'(exp_q.size()), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
